// File: rtl/apb_i2c_pkg.sv
// Shared register map, STAT/CTRL bit positions and APB FSM encoding for the
// APB-to-I2C bridge register slave.
package apb_i2c_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_SADDR  = 8'h01;
  localparam logic [7:0] ADDR_PRESC  = 8'h02;
  localparam logic [7:0] ADDR_TXD    = 8'h03;
  localparam logic [7:0] ADDR_RXD    = 8'h04;
  localparam logic [7:0] ADDR_STAT   = 8'h05;
  localparam logic [7:0] ADDR_RXDROP = 8'h06;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_START   = 1;
  localparam int CTRL_STOP    = 2;
  localparam int CTRL_IE      = 3;
  localparam int CTRL_TXFLUSH = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_TXFULL  = 1;
  localparam int STAT_RXEMPTY = 2;
  localparam int STAT_TXEMPTY = 3;
  localparam int STAT_DONE    = 4;
  localparam int STAT_NACK    = 5;
  localparam int STAT_TXOVF   = 6;
  localparam int STAT_RXUNF   = 7;

  localparam logic [7:0] PRESC_RESET = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // A zero divider would stall SCL, so it is promoted to the fastest legal value.
  function automatic logic [7:0] presc_sanitize(input logic [7:0] value);
    return (value == 8'h00) ? 8'h01 : value;
  endfunction

endpackage

// File: rtl/i2c_byte_fifo.sv
// 8-bit synchronous FIFO with flush; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module i2c_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          preset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (preset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/apb_i2c_reg_slave.sv
// APB slave front end of the APB-to-I2C bridge: register file, TX/RX byte
// FIFOs, sticky status/interrupt and start/stop command pulses to the core.
module apb_i2c_reg_slave
  import apb_i2c_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata_in,
  output logic [7:0] prdata_out,
  output logic       pready,
  output logic       i2c_start,
  output logic       i2c_stop,
  output logic [6:0] i2c_slv_addr,
  output logic       i2c_rw,
  output logic [7:0] i2c_prescale,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       i2c_busy,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  apb_state_e    state_q;
  logic [2:0]    wait_q;
  logic          pready_q, rd_empty_q;
  logic [7:0]    prdata_q;

  logic          en_q, ie_q, start_q, stop_q;
  logic [7:0]    saddr_q, presc_q, rx_drop_q;
  logic [3:0]    sticky_q, sticky_d;
  logic [3:0]    sticky_set, sticky_clr;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    tx_head, rx_head, stat, rd_value;

  logic          commit, wr_commit, rd_commit;
  logic          wr_ctrl, wr_saddr, wr_presc, wr_stat, rd_rxd;
  logic          tx_push, tx_pop, tx_flush, tx_ovf;
  logic          rx_pop, rx_drop, rx_unf;

  assign commit    = (state_q == ACCESS) && pready_q && psel;
  assign wr_commit = commit && pwrite;
  assign rd_commit = commit && !pwrite;
  assign wr_ctrl   = wr_commit && (paddr == ADDR_CTRL);
  assign wr_saddr  = wr_commit && (paddr == ADDR_SADDR);
  assign wr_presc  = wr_commit && (paddr == ADDR_PRESC);
  assign wr_stat   = wr_commit && (paddr == ADDR_STAT);
  assign rd_rxd    = rd_commit && (paddr == ADDR_RXD);

  assign tx_push  = wr_commit && (paddr == ADDR_TXD);
  assign tx_pop   = tx_ready && !tx_empty;
  assign tx_flush = wr_ctrl && pwdata_in[CTRL_TXFLUSH];
  assign tx_ovf   = tx_push && tx_full && !tx_pop;

  // RX emptiness is judged when the read data was captured, so a byte landing
  // during the pready cycle is never popped without having been returned.
  assign rx_pop  = rd_rxd && !rd_empty_q;
  assign rx_unf  = rd_rxd && rd_empty_q;
  assign rx_drop = rx_valid && rx_full && !rx_pop;

  always_comb begin
    stat               = 8'h00;
    stat[STAT_BUSY]    = i2c_busy;
    stat[STAT_TXFULL]  = tx_full;
    stat[STAT_RXEMPTY] = rx_empty;
    stat[STAT_TXEMPTY] = tx_empty;
    stat[STAT_RXUNF:STAT_DONE] = sticky_q;
  end

  always_comb begin
    rd_value = 8'h00;
    if (!pwrite) begin
      case (paddr)
        ADDR_CTRL:   rd_value = {4'b0000, ie_q, 2'b00, en_q};
        ADDR_SADDR:  rd_value = saddr_q;
        ADDR_PRESC:  rd_value = presc_q;
        ADDR_RXD:    rd_value = rx_head;
        ADDR_STAT:   rd_value = stat;
        ADDR_RXDROP: rd_value = rx_drop_q;
        default:     rd_value = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (preset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      pready_q   <= 1'b0;
      prdata_q   <= 8'h00;
      rd_empty_q <= 1'b0;
    end else begin
      pready_q <= 1'b0;
      prdata_q <= 8'h00;
      unique case (state_q)
        IDLE: if (psel && !penable) state_q <= SETUP;
        SETUP: begin
          if (!psel) begin
            state_q <= IDLE;
          end else begin
            state_q <= ACCESS;
            wait_q  <= WAIT_INIT;
            if (WAIT_INIT == 3'd0) begin
              pready_q   <= 1'b1;
              prdata_q   <= rd_value;
              rd_empty_q <= (rx_count == '0);
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_q <= IDLE;
          end else if (pready_q) begin
            state_q <= !penable ? SETUP : IDLE;
          end else begin
            wait_q <= wait_q - 3'd1;
            if (wait_q == 3'd1) begin
              pready_q   <= 1'b1;
              prdata_q   <= rd_value;
              rd_empty_q <= (rx_count == '0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky order matches STAT[7:4]: rxunf, txovf, nack, done. Set beats clear.
  assign sticky_set = {rx_unf, tx_ovf, i2c_nack, i2c_done};
  assign sticky_clr = wr_stat ? pwdata_in[STAT_RXUNF:STAT_DONE] : 4'b0000;
  assign sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;

  always_ff @(posedge clk) begin
    if (preset) begin
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      saddr_q   <= 8'h00;
      presc_q   <= PRESC_RESET;
      sticky_q  <= 4'b0000;
      rx_drop_q <= 8'h00;
    end else begin
      start_q  <= wr_ctrl && pwdata_in[CTRL_START] && en_q && !i2c_busy;
      stop_q   <= wr_ctrl && pwdata_in[CTRL_STOP];
      sticky_q <= sticky_d;
      if (wr_ctrl) begin
        en_q <= pwdata_in[CTRL_EN];
        ie_q <= pwdata_in[CTRL_IE];
      end
      if (wr_saddr) saddr_q <= pwdata_in;
      if (wr_presc) presc_q <= presc_sanitize(pwdata_in);
      if (rx_drop && (rx_drop_q != 8'hFF)) rx_drop_q <= rx_drop_q + 8'd1;
    end
  end

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .preset  (preset),
    .flush_i (tx_flush),
    .push_i  (tx_push),
    .data_i  (pwdata_in),
    .pop_i   (tx_ready),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  i2c_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .preset  (preset),
    .flush_i (1'b0),
    .push_i  (rx_valid),
    .data_i  (rx_data),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign pready       = pready_q;
  assign prdata_out   = prdata_q;
  assign i2c_start    = start_q;
  assign i2c_stop     = stop_q;
  assign i2c_slv_addr = saddr_q[6:0];
  assign i2c_rw       = saddr_q[7];
  assign i2c_prescale = presc_q;
  assign tx_data      = tx_head;
  assign tx_valid     = (tx_count != '0);
  assign irq          = ie_q && (sticky_q != 4'b0000);

endmodule

// File: tb/tb_apb_i2c_reg_slave.sv
// Self-checking bench for apb_i2c_reg_slave: directed scenarios followed by
// random APB/core traffic, compared against a queue-based register model.
module tb_apb_i2c_reg_slave;

  localparam int WS    = 1;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       preset, psel, penable, pwrite;
  logic [7:0] paddr, pwdata_in, prdata_out;
  logic       pready, i2c_start, i2c_stop, i2c_rw;
  logic [6:0] i2c_slv_addr;
  logic [7:0] i2c_prescale, tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, i2c_busy, i2c_done, i2c_nack, irq;

  always #5 clk = ~clk;

  apb_i2c_reg_slave #(.WAIT_STATES(WS), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata_in(pwdata_in), .prdata_out(prdata_out), .pready(pready),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_slv_addr(i2c_slv_addr),
    .i2c_rw(i2c_rw), .i2c_prescale(i2c_prescale), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .i2c_busy(i2c_busy), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .irq(irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: sticky order is {rxunf, txovf, nack, done}.
  bit         m_en, m_ie, m_busy, exp_start, exp_stop;
  logic [7:0] m_saddr, m_presc, m_drop;
  logic [3:0] m_sticky;
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];

  function automatic void model_reset();
    m_en = 0; m_ie = 0; m_saddr = 8'h00; m_presc = 8'h04; m_drop = 8'h00;
    m_sticky = 4'h0; m_txq.delete(); m_rxq.delete();
  endfunction

  function automatic logic [7:0] model_stat();
    logic [7:0] s;
    s = {m_sticky, 4'b0000};
    s[0] = m_busy;
    s[1] = (m_txq.size() == DEPTH);
    s[2] = (m_rxq.size() == 0);
    s[3] = (m_txq.size() == 0);
    return s;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] addr);
    case (addr)
      8'h00: return {4'b0000, m_ie, 2'b00, m_en};
      8'h01: return m_saddr;
      8'h02: return m_presc;
      8'h04: return (m_rxq.size() != 0) ? m_rxq[0] : 8'h00;
      8'h05: return model_stat();
      8'h06: return m_drop;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_commit(input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    exp_start = 0;
    exp_stop  = 0;
    if (!wr) begin
      if (addr == 8'h04) begin
        if (m_rxq.size() != 0) void'(m_rxq.pop_front());
        else m_sticky[3] = 1'b1;
      end
    end else begin
      case (addr)
        8'h00: begin
          exp_start = wd[1] && m_en && !m_busy;
          exp_stop  = wd[2];
          m_en = wd[0];
          m_ie = wd[3];
          if (wd[4]) m_txq.delete();
        end
        8'h01: m_saddr = wd;
        8'h02: m_presc = (wd == 8'h00) ? 8'h01 : wd;
        8'h03: if (m_txq.size() < DEPTH) m_txq.push_back(wd); else m_sticky[2] = 1'b1;
        8'h05: m_sticky = m_sticky & ~wd[7:4];
        default: ;
      endcase
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, "_txvalid"}, tx_valid, m_txq.size() != 0);
    check({tag, "_txdata"}, tx_data, (m_txq.size() != 0) ? m_txq[0] : 8'h00);
    check({tag, "_irq"}, irq, m_ie && (m_sticky != 4'h0));
    check({tag, "_presc"}, i2c_prescale, m_presc);
    check({tag, "_saddr"}, {i2c_rw, i2c_slv_addr}, m_saddr);
    check({tag, "_pready_idle"}, pready, 1'b0);
    check({tag, "_prdata_idle"}, prdata_out, 8'h00);
  endtask

  // Starts and ends one cycle past a rising edge; lat counts penable cycles up to pready.
  task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                          input bit pulse_done, output logic [7:0] rdata, output int lat);
    bit got_ready;
    got_ready = 0;
    rdata = 8'h00;
    lat = 0;
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata_in = wd;
    @(posedge clk); #1 penable = 1;
    for (int i = 0; i < 20 && !got_ready; i++) begin
      lat++;
      if (pready === 1'b1) begin
        rdata = prdata_out;
        got_ready = 1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("pready_seen", got_ready, 1'b1);
    if (pulse_done) i2c_done = 1;
    @(posedge clk); #1;
    i2c_done = 0; psel = 0; penable = 0;
  endtask

  task automatic do_apb(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                        input bit pulse_done, output logic [7:0] rdata);
    logic [7:0] exp_rd;
    int lat;
    exp_rd = wr ? 8'h00 : model_read(addr);
    apb_xfer(wr, addr, wd, pulse_done, rdata, lat);
    // one decode cycle (FSM SETUP) precedes the WS wait cycles of ACCESS
    check("latency", lat, WS + 2);
    check($sformatf("prdata_a%0h", addr), rdata, exp_rd);
    model_commit(wr, addr, wd);
    if (pulse_done) m_sticky[0] = 1'b1;
    check("start_pulse", i2c_start, exp_start);
    check("stop_pulse", i2c_stop, exp_stop);
    check_outputs("apb");
  endtask

  task automatic core_evt(input bit rv, input logic [7:0] rd, input bit tr,
                          input bit dn, input bit nk, input bit bz);
    rx_valid = rv; rx_data = rd; tx_ready = tr; i2c_done = dn; i2c_nack = nk; i2c_busy = bz;
    @(posedge clk); #1;
    rx_valid = 0; tx_ready = 0; i2c_done = 0; i2c_nack = 0;
    if (tr && m_txq.size() != 0) void'(m_txq.pop_front());
    if (rv) begin
      if (m_rxq.size() < DEPTH) m_rxq.push_back(rd);
      else if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    end
    if (dn) m_sticky[0] = 1'b1;
    if (nk) m_sticky[1] = 1'b1;
    m_busy = bz;
    check("evt_start_idle", i2c_start, 1'b0);
    check_outputs("evt");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] exp_tx[4];
    exp_tx[0] = 8'hAA; exp_tx[1] = 8'hBB; exp_tx[2] = 8'hCC; exp_tx[3] = 8'hDD;

    preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata_in = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0; i2c_busy = 0; i2c_done = 0; i2c_nack = 0;
    m_busy = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", i2c_start, 1'b0);
    check("rst_stop", i2c_stop, 1'b0);
    check_outputs("rst");
    preset = 0;

    // 1: prescaler reset value and wait-state timing
    do_apb(0, 8'h02, 8'h00, 0, rd);
    check("t1_presc", rd, 8'h04);

    // 2: TX fill past full
    foreach (exp_tx[i]) do_apb(1, 8'h03, exp_tx[i], 0, rd);
    do_apb(1, 8'h03, 8'hEE, 0, rd);
    check("t2_txhead", tx_data, 8'hAA);
    do_apb(0, 8'h05, 8'h00, 0, rd);
    check("t2_stat", rd, 8'h46);
    for (int i = 0; i < 4; i++) begin
      check("t2_pop", tx_data, exp_tx[i]);
      core_evt(0, 8'h00, 1, 0, 0, 0);
    end
    check("t2_empty", tx_valid, 1'b0);

    // 3: start gating on enable and busy
    do_apb(1, 8'h00, 8'h01, 0, rd);
    do_apb(1, 8'h00, 8'h03, 0, rd);
    check("t3_start", i2c_start, 1'b1);
    @(posedge clk); #1;
    check("t3_start_width", i2c_start, 1'b0);
    core_evt(0, 8'h00, 0, 0, 0, 1);
    do_apb(1, 8'h00, 8'h03, 0, rd);
    check("t3_busy_nostart", i2c_start, 1'b0);
    core_evt(0, 8'h00, 0, 0, 0, 0);

    // 4: interrupt, W1C and set-beats-clear
    do_apb(1, 8'h05, 8'hF0, 0, rd);
    do_apb(1, 8'h00, 8'h09, 0, rd);
    core_evt(0, 8'h00, 0, 1, 1, 0);
    check("t4_irq", irq, 1'b1);
    do_apb(0, 8'h05, 8'h00, 0, rd);
    check("t4_stat54", rd[5:4], 2'b11);
    do_apb(1, 8'h05, 8'h30, 0, rd);
    check("t4_irq_clr", irq, 1'b0);
    do_apb(1, 8'h05, 8'h10, 1, rd);
    do_apb(0, 8'h05, 8'h00, 0, rd);
    check("t4_done_kept", rd[4], 1'b1);

    // 5: RX read then underflow
    do_apb(1, 8'h05, 8'hF0, 0, rd);
    core_evt(1, 8'h5A, 0, 0, 0, 0);
    do_apb(0, 8'h04, 8'h00, 0, rd);
    check("t5_rx", rd, 8'h5A);
    do_apb(0, 8'h04, 8'h00, 0, rd);
    check("t5_rx_empty", rd, 8'h00);
    do_apb(0, 8'h05, 8'h00, 0, rd);
    check("t5_rxunf", rd[7], 1'b1);

    // RX overflow counter
    for (int i = 0; i < DEPTH + 2; i++) core_evt(1, 8'(8'h10 + i), 0, 0, 0, 0);
    do_apb(0, 8'h06, 8'h00, 0, rd);
    check("rx_drop_cnt", rd, 8'h02);
    do_apb(0, 8'h04, 8'h00, 0, rd);
    check("rx_keep_oldest", rd, 8'h10);

    // 6: reset during ACCESS of a TXD write
    do_apb(1, 8'h02, 8'h20, 0, rd);
    do_apb(1, 8'h01, 8'hC5, 0, rd);
    psel = 1; penable = 0; pwrite = 1; paddr = 8'h03; pwdata_in = 8'h77;
    @(posedge clk); #1 penable = 1;
    @(posedge clk); #1;
    preset = 1;
    @(posedge clk); #1;
    check("t6_pready", pready, 1'b0);
    psel = 0; penable = 0;
    @(posedge clk); #1;
    preset = 0;
    model_reset();
    check_outputs("t6");
    do_apb(0, 8'h05, 8'h00, 0, rd);
    check("t6_stat", rd, 8'h0C);
    do_apb(0, 8'h06, 8'h00, 0, rd);
    check("t6_drop", rd, 8'h00);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        int unsigned sel;
        logic [7:0] a, d;
        bit w;
        sel = $urandom_range(0, 12);
        if (sel < 8)       a = 8'(sel);
        else if (sel < 10) a = 8'h03;
        else if (sel < 12) a = 8'h04;
        else               a = 8'($urandom_range(7, 255));
        w = ($urandom_range(0, 1) == 1);
        d = 8'($urandom);
        if (a == 8'h00 && $urandom_range(0, 3) != 0) d[4] = 1'b0;
        do_apb(w, a, d, 1'b0, rd);
      end else begin
        core_evt($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
